// File: rtl/lector_rom.sv
`default_nettype none
//==============================================================================
// Module   : lector_rom
// Purpose  : Address sequencer and read front-end for the 256 x 8
//            combinational rom. On an accepted start pulse it walks the
//            inclusive address range dir_inicio..dir_fin (wrapping through
//            255 -> 0), registers each returned word and hands it
//            downstream on a valid/ready stream. One word per two cycles at
//            best (LEER + ENTREGAR).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk         in   1  clock, rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   inicio      in   1  start pulse, honoured only while idle (REPOSO)
//   dir_inicio  in   8  first address, latched on accepted inicio
//   dir_fin     in   8  last address (inclusive), latched on accepted inicio
//   direccion   out  8  registered address to rom.direccion
//   dato_rom    in   8  word from rom.dato_s (combinational from direccion)
//   dato_s      out  8  registered word presented downstream
//   valido      out  1  dato_s holds a word not yet accepted
//   listo       in   1  downstream ready
//   ocupado     out  1  high while reading/delivering (LEER, ENTREGAR)
//   fin         out  1  one-cycle pulse after the last word is accepted
//   suma        out  8  running mod-256 checksum of delivered words
//                       (only when LECTOR_ROM_CHECKSUM_EN is defined)
//
// Build option
//   LECTOR_ROM_CHECKSUM_EN : adds the suma port and its accumulator.
//==============================================================================
module lector_rom (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inicio,
   input  logic [7:0] dir_inicio,
   input  logic [7:0] dir_fin,
   output logic [7:0] direccion,
   input  logic [7:0] dato_rom,
   output logic [7:0] dato_s,
   output logic       valido,
   input  logic       listo,
   output logic       ocupado,
   output logic       fin
`ifdef LECTOR_ROM_CHECKSUM_EN
   ,
   output logic [7:0] suma
`endif
);

   // FSM encoding
   localparam logic [1:0] REPOSO   = 2'd0;
   localparam logic [1:0] LEER     = 2'd1;
   localparam logic [1:0] ENTREGAR = 2'd2;
   localparam logic [1:0] FIN      = 2'd3;

   logic [1:0] r_estado;
   logic [7:0] r_direccion;
   logic [7:0] r_fin_dir;
   logic [7:0] r_dato;
   logic       r_valido;
   logic       r_ocupado;
   logic       r_fin;

   logic       w_acepta;
   logic       w_handshake;
   logic       w_ultima;

   assign w_acepta    = (r_estado == REPOSO) && inicio;
   assign w_handshake = (r_estado == ENTREGAR) && r_valido && listo;
   // Comparing against the latched end address (rather than counting words)
   // makes the wrap and full-256 cases fall out naturally: the range ends
   // the first time the incrementing address equals the end address.
   assign w_ultima    = (r_direccion == r_fin_dir);

   //---------------------------------------------------------------------------
   // Sequencer. ocupado and fin are registered alongside the state so that
   // neither listo nor inicio reaches an output combinationally.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado    <= REPOSO;
         r_direccion <= 8'h00;
         r_fin_dir   <= 8'h00;
         r_dato      <= 8'h00;
         r_valido    <= 1'b0;
         r_ocupado   <= 1'b0;
         r_fin       <= 1'b0;
      end else begin
         case (r_estado)
            REPOSO: begin
               if (w_acepta) begin
                  r_direccion <= dir_inicio;
                  r_fin_dir   <= dir_fin;
                  r_ocupado   <= 1'b1;
                  r_estado    <= LEER;
               end
            end

            LEER: begin
               // ROM output has had a full cycle to settle on r_direccion.
               r_dato   <= dato_rom;
               r_valido <= 1'b1;
               r_estado <= ENTREGAR;
            end

            ENTREGAR: begin
               // dato_s/valido are untouched until the handshake.
               if (w_handshake) begin
                  r_valido <= 1'b0;
                  if (w_ultima) begin
                     r_ocupado <= 1'b0;
                     r_fin     <= 1'b1;
                     r_estado  <= FIN;
                  end else begin
                     r_direccion <= r_direccion + 8'd1;
                     r_estado    <= LEER;
                  end
               end
            end

            FIN: begin
               r_fin    <= 1'b0;
               r_estado <= REPOSO;
            end

            default: begin
               r_valido  <= 1'b0;
               r_ocupado <= 1'b0;
               r_fin     <= 1'b0;
               r_estado  <= REPOSO;
            end
         endcase
      end
   end

`ifdef LECTOR_ROM_CHECKSUM_EN
   //---------------------------------------------------------------------------
   // Checksum: cleared on a new range, accumulates the word being accepted.
   // Holds its final value from the FIN cycle until the next accepted start.
   //---------------------------------------------------------------------------
   logic [7:0] r_suma;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_suma <= 8'h00;
      end else if (w_acepta) begin
         r_suma <= 8'h00;
      end else if (w_handshake) begin
         r_suma <= r_suma + r_dato;
      end
   end

   assign suma = r_suma;
`endif

   assign direccion = r_direccion;
   assign dato_s    = r_dato;
   assign valido    = r_valido;
   assign ocupado   = r_ocupado;
   assign fin       = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_lector_rom.sv
`default_nettype none
//==============================================================================
// Module   : tb_lector_rom
// Purpose  : Self-checking bench for lector_rom. The ROM is modelled as
//            dato_rom = direccion ^ 8'hA5. Expected word streams come from
//            a range model (count = ((fin-ini) mod 256)+1, data = addr^A5).
// Revision : 1.0 - initial release
//==============================================================================
module tb_lector_rom;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inicio;
   logic [7:0] dir_inicio;
   logic [7:0] dir_fin;
   logic [7:0] direccion;
   logic [7:0] dato_rom;
   logic [7:0] dato_s;
   logic       valido;
   logic       listo;
   logic       ocupado;
   logic       fin;
`ifdef LECTOR_ROM_CHECKSUM_EN
   logic [7:0] suma;
`endif

   always #5 clk = ~clk;

   assign dato_rom = direccion ^ 8'hA5;

   lector_rom dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inicio     (inicio),
      .dir_inicio (dir_inicio),
      .dir_fin    (dir_fin),
      .direccion  (direccion),
      .dato_rom   (dato_rom),
      .dato_s     (dato_s),
      .valido     (valido),
      .listo      (listo),
      .ocupado    (ocupado),
      .fin        (fin)
`ifdef LECTOR_ROM_CHECKSUM_EN
      ,
      .suma       (suma)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are checked there
   // or at the falling edge, never on the active edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   //---------------------------------------------------------------------------
   // Stream monitor: records accepted words/addresses, checks hold-while-stalled
   // and that fin is a single-cycle pulse with the block already idle.
   //---------------------------------------------------------------------------
   logic [7:0] got_d[$];
   logic [7:0] got_a[$];
   int         fin_cnt   = 0;
   logic       prev_fin  = 1'b0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_dato = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold <= 1'b0;
         prev_fin  <= 1'b0;
      end else begin
         if (prev_hold)
            chk("hold", 32'({valido, dato_s}), 32'({1'b1, prev_dato}));
         if (fin) begin
            fin_cnt <= fin_cnt + 1;
            chk("fin_pulse", 32'({prev_fin, valido, ocupado}), 32'(3'b000));
         end
         if (valido && listo) begin
            got_d.push_back(dato_s);
            got_a.push_back(direccion);
         end
         prev_hold <= valido && !listo;
         prev_dato <= dato_s;
         prev_fin  <= fin;
      end
   end

   task automatic chk_idle(input string nm);
      chk(nm, 32'({direccion, dato_s, valido, ocupado, fin}), 32'(0));
`ifdef LECTOR_ROM_CHECKSUM_EN
      chk({nm, "_suma"}, 32'(suma), 32'(0));
`endif
   endtask

   //---------------------------------------------------------------------------
   // Run one range with random backpressure and compare against the model.
   //---------------------------------------------------------------------------
   task automatic run_range(input logic [7:0] s, input logic [7:0] e,
                            input int listo_pct, input bit repulse, input string nm);
      logic [7:0] exp_d[$];
      logic [7:0] exp_a[$];
      logic [7:0] exp_sum;
      int         n;
      int         start_fin;
      int         cyc;
      int         mism;
      bit         done;
      n       = ((int'(e) - int'(s) + 256) % 256) + 1;
      exp_sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_a.push_back(8'(int'(s) + i));
         exp_d.push_back(8'(int'(s) + i) ^ 8'hA5);
         exp_sum = exp_sum + (8'(int'(s) + i) ^ 8'hA5);
      end
      got_d.delete();
      got_a.delete();
      start_fin  = fin_cnt;
      dir_inicio = s;
      dir_fin    = e;
      inicio     = 1'b1;
      listo      = 1'($urandom_range(1));
      tick();
      inicio     = 1'b0;
      dir_inicio = 8'($urandom);
      dir_fin    = 8'($urandom);
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 6000) begin
         listo = (int'($urandom_range(99)) < listo_pct);
         if (repulse && cyc > 2) begin
            inicio     = 1'($urandom_range(1));
            dir_inicio = 8'h00;
            dir_fin    = 8'h0F;
         end else begin
            inicio = 1'b0;
         end
         tick();
         cyc++;
         if (fin_cnt != start_fin) done = 1'b1;
      end
      inicio = 1'b0;
      listo  = 1'b0;
      chk({nm, "_timeout"}, 32'(done), 32'(1));
      tick();
      tick();
      chk({nm, "_fincount"}, 32'(fin_cnt - start_fin), 32'(1));
      chk({nm, "_words"}, 32'(got_d.size()), 32'(n));
      mism = 0;
      for (int i = 0; i < n && i < got_d.size(); i++) begin
         if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin
            if (mism == 0)
               $display("FAIL %s_word%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                        nm, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
            mism++;
         end
      end
      chk({nm, "_data_mismatches"}, 32'(mism), 32'(0));
      chk({nm, "_idle_after"}, 32'({valido, ocupado, fin}), 32'(0));
`ifdef LECTOR_ROM_CHECKSUM_EN
      chk({nm, "_suma"}, 32'(suma), 32'(exp_sum));
`else
      if (exp_sum == 8'h00) begin end
`endif
   endtask

   //---------------------------------------------------------------------------
   // Directed vector table: range 3..6 with listo held high.
   //---------------------------------------------------------------------------
   typedef struct {
      logic       inicio;
      logic       listo;
      logic [7:0] dir;
      logic [7:0] dato;
      logic       valido;
      logic       ocupado;
      logic       fin;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_fin;
      bit seen;
      logic [7:0] rs, re;

      //                inicio listo  dir    dato   vld   ocp   fin
      tbl[0]  = '{1'b1, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 8'h03, 8'hA6, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 8'h04, 8'hA6, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 8'h04, 8'hA1, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 8'h05, 8'hA1, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 8'h05, 8'hA0, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 8'h06, 8'hA0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 8'h06, 8'hA3, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'h06, 8'hA3, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 8'h06, 8'hA3, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'h06, 8'hA3, 1'b0, 1'b0, 1'b0};

      // Reset and idle
      rst_n      = 1'b0;
      inicio     = 1'b0;
      listo      = 1'b0;
      dir_inicio = 8'h00;
      dir_fin    = 8'h00;
      #1;
      chk_idle("reset_async");
      repeat (3) tick();
      chk_idle("reset_held");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         listo = 1'($urandom_range(1));
         tick();
         chk_idle($sformatf("idle%0d", i));
      end
      listo = 1'b0;

      // Table: 3..6, listo=1
      got_d.delete();
      got_a.delete();
      for (int i = 0; i < 11; i++) begin
         inicio     = tbl[i].inicio;
         listo      = tbl[i].listo;
         dir_inicio = 8'h03;
         dir_fin    = 8'h06;
         tick();
         chk($sformatf("vec%0d", i),
             32'({direccion, dato_s, valido, ocupado, fin}),
             32'({tbl[i].dir, tbl[i].dato, tbl[i].valido, tbl[i].ocupado, tbl[i].fin}));
      end
      chk("vec_words", 32'(got_d.size()), 32'(4));
`ifdef LECTOR_ROM_CHECKSUM_EN
      chk("vec_suma", 32'(suma), 32'(8'h8A));
`endif
      listo = 1'b0;

      // Single word at 9 with 5 stall cycles
      got_d.delete();
      got_a.delete();
      dir_inicio = 8'h09;
      dir_fin    = 8'h09;
      inicio     = 1'b1;
      tick();
      inicio = 1'b0;
      tick();
      chk("single_first", 32'({valido, dato_s, ocupado}), 32'({1'b1, 8'hAC, 1'b1}));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("single_stall%0d", i), 32'({valido, dato_s, fin}), 32'({1'b1, 8'hAC, 1'b0}));
      end
      listo = 1'b1;
      tick();
      chk("single_fin", 32'({fin, valido, ocupado}), 32'(3'b100));
      listo = 1'b0;
      tick();
      chk("single_fin_end", 32'(fin), 32'(0));
      chk("single_words", 32'(got_d.size()), 32'(1));
`ifdef LECTOR_ROM_CHECKSUM_EN
      chk("single_suma", 32'(suma), 32'(8'hAC));
`endif

      // Wrap and full range, re-pulsed inicio
      run_range(8'd254, 8'd1, 100, 1'b0, "wrap");
      run_range(8'd40, 8'd52, 60, 1'b1, "repulse");
      run_range(8'd16, 8'd15, 70, 1'b1, "full");

      // Random ranges
      for (int r = 0; r < 5; r++) begin
         rs = 8'($urandom_range(255));
         re = 8'(int'(rs) + int'($urandom_range(40)));
         run_range(rs, re, int'($urandom_range(30, 100)), 1'($urandom_range(1)),
                   $sformatf("rand%0d", r));
      end

      // Reset mid-range (0..15) while in ENTREGAR
      dir_inicio = 8'h00;
      dir_fin    = 8'h0F;
      inicio     = 1'b1;
      listo      = 1'b1;
      tick();
      inicio = 1'b0;
      repeat (5) tick();
      listo = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         tick();
         if (valido) seen = 1'b1;
      end
      chk("prerst_entregar", 32'({seen, valido, ocupado}), 32'(3'b111));
      start_fin = fin_cnt;
      #1;
      rst_n = 1'b0;
      #1;
      chk_idle("midrun_rst");
      repeat (3) tick();
      rst_n = 1'b1;
      listo = 1'b1;
      repeat (4) tick();
      chk("midrun_nofin", 32'(fin_cnt - start_fin), 32'(0));
      chk_idle("midrun_after");
      run_range(8'd0, 8'd2, 100, 1'b0, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
